cdb_arbiter: RTL

//  Shares the single common data bus (CDB) between the two result producers: the reservation-station ALU
//  and the load/store buffer. Buffers each producer's results in a small FIFO, grants the bus round-robin,
//  and drives one registered broadcast per cycle to the ROB and to the RS/LSB operand-wakeup logic.

---
 rtl/cdb_arbiter_pkg.sv | 38 +++
 rtl/cdb_arbiter_if.sv | 35 +++
 rtl/cdb_arbiter_result_fifo.sv | 73 +++++++
 rtl/cdb_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and widths for the CDB arbiter: source ids, result record and broadcast payload.
package cdb_arbiter_pkg;

    localparam int unsigned ROB_WIDTH  = 4;
    localparam int unsigned FIFO_WIDTH = 2;
    localparam int unsigned DEPTH      = 1 << FIFO_WIDTH;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned REC_WIDTH  = DATA_WIDTH + ROB_WIDTH;
    localparam int unsigned CNT_WIDTH  = FIFO_WIDTH + 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSB = 1'b1
    } src_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] val;
        logic [ROB_WIDTH-1:0]  dest;
    } cdb_rec_t;

    typedef struct packed {
        logic     flag;
        src_e     src;
        cdb_rec_t rec;
    } cdb_bcast_t;

    // Round-robin choice between two requesters; a tie goes to the source not granted last.
    function automatic src_e rr_pick(input logic alu_req, input logic lsb_req, input src_e last);
        if (alu_req && lsb_req) begin
            return (last == SRC_ALU) ? SRC_LSB : SRC_ALU;
        end
        if (lsb_req) begin
            return SRC_LSB;
        end
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB arbiter, grouped as one bus.
interface cdb_arbiter_if;
    import cdb_arbiter_pkg::*;

    logic                  aluFlag;
    logic [DATA_WIDTH-1:0] aluVal;
    logic [ROB_WIDTH-1:0]  aluDest;
    logic                  aluStall;

    logic                  lsbFlag;
    logic [DATA_WIDTH-1:0] lsbVal;
    logic [ROB_WIDTH-1:0]  lsbDest;
    logic                  lsbStall;

    logic                  cdbFlag;
    logic [DATA_WIDTH-1:0] cdbVal;
    logic [ROB_WIDTH-1:0]  cdbDest;
    logic                  cdbSrc;
    logic                  overflow;

    modport master (
        output aluFlag, aluVal, aluDest,
        output lsbFlag, lsbVal, lsbDest,
        input  aluStall, lsbStall,
        input  cdbFlag, cdbVal, cdbDest, cdbSrc, overflow
    );

    modport slave (
        input  aluFlag, aluVal, aluDest,
        input  lsbFlag, lsbVal, lsbDest,
        output aluStall, lsbStall,
        output cdbFlag, cdbVal, cdbDest, cdbSrc, overflow
    );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// DEPTH-entry result FIFO with enable, flush, same-cycle push/pop and overflow-drop detection.
module result_fifo
    import cdb_arbiter_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     en_i,
    input  logic     flush_i,
    input  logic     push_i,
    input  cdb_rec_t data_i,
    input  logic     pop_i,
    output cdb_rec_t head_c_o,
    output logic     empty_c_o,
    output logic     near_full_c_o,
    output logic     drop_c_o
);

    logic [REC_WIDTH-1:0]  mem_q [DEPTH];
    logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  count_q,  count_d;

    logic live;
    logic full;
    logic pop_ok;
    logic push_ok;

    assign live    = en_i && !flush_i;
    assign full    = (count_q == CNT_WIDTH'(DEPTH));
    assign pop_ok  = live && pop_i && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push_ok = live && push_i && (!full || pop_ok);

    assign head_c_o      = cdb_rec_t'(mem_q[rd_ptr_q]);
    assign empty_c_o     = (count_q == '0);
    assign near_full_c_o = (count_q >= CNT_WIDTH'(DEPTH - 1));
    assign drop_c_o      = live && push_i && full && !pop_ok;

    always_comb begin : next_ptrs
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (en_i && flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + FIFO_WIDTH'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + FIFO_WIDTH'(1);
            count_d = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : ptr_regs
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is only ever read behind a non-zero count, so it needs no reset.
    always_ff @(posedge clk) begin : storage
        if (push_ok) begin
            mem_q[wr_ptr_q] <= REC_WIDTH'(data_i);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the CDB between the ALU and LSB result FIFOs, one registered broadcast per cycle.
// Optional CDB_BYPASS_EN: an empty winning FIFO with a live push goes straight to the bus (1-edge latency).
module cdb_arbiter
    import cdb_arbiter_pkg::*;
(
    input  logic          clockIn,
    input  logic          resetIn,
    input  logic          readyIn,
    input  logic          flushIn,
    cdb_arbiter_if.slave  bus
);

    cdb_bcast_t bcast_q, bcast_d;
    src_e       last_q,  last_d;
    logic       overflow_q, overflow_d;

    cdb_rec_t alu_in, lsb_in;
    cdb_rec_t alu_head, lsb_head;
    logic     alu_empty, lsb_empty;
    logic     alu_near_full, lsb_near_full;
    logic     alu_drop, lsb_drop;
    logic     alu_req, lsb_req;
    logic     alu_push, lsb_push;
    logic     alu_pop, lsb_pop;
    logic     grant_vld;
    src_e     grant_src;
    cdb_rec_t grant_rec;

    assign alu_in = '{val: bus.aluVal, dest: bus.aluDest};
    assign lsb_in = '{val: bus.lsbVal, dest: bus.lsbDest};

`ifdef CDB_BYPASS_EN
    logic alu_byp, lsb_byp;

    assign alu_req   = !alu_empty || bus.aluFlag;
    assign lsb_req   = !lsb_empty || bus.lsbFlag;
    assign grant_vld = alu_req || lsb_req;
    assign grant_src = rr_pick(alu_req, lsb_req, last_q);

    assign alu_byp   = grant_vld && (grant_src == SRC_ALU) && alu_empty;
    assign lsb_byp   = grant_vld && (grant_src == SRC_LSB) && lsb_empty;
    assign alu_push  = bus.aluFlag && !alu_byp;
    assign lsb_push  = bus.lsbFlag && !lsb_byp;
    assign alu_pop   = grant_vld && (grant_src == SRC_ALU) && !alu_empty;
    assign lsb_pop   = grant_vld && (grant_src == SRC_LSB) && !lsb_empty;

    always_comb begin : grant_data
        grant_rec = lsb_byp ? lsb_in : lsb_head;
        if (grant_src == SRC_ALU) begin
            grant_rec = alu_byp ? alu_in : alu_head;
        end
    end
`else
    assign alu_req   = !alu_empty;
    assign lsb_req   = !lsb_empty;
    assign grant_vld = alu_req || lsb_req;
    assign grant_src = rr_pick(alu_req, lsb_req, last_q);

    assign alu_push  = bus.aluFlag;
    assign lsb_push  = bus.lsbFlag;
    assign alu_pop   = grant_vld && (grant_src == SRC_ALU);
    assign lsb_pop   = grant_vld && (grant_src == SRC_LSB);

    always_comb begin : grant_data
        grant_rec = (grant_src == SRC_ALU) ? alu_head : lsb_head;
    end
`endif

    result_fifo u_alu_fifo (
        .clk           (clockIn),
        .rst_n         (resetIn),
        .en_i          (readyIn),
        .flush_i       (flushIn),
        .push_i        (alu_push),
        .data_i        (alu_in),
        .pop_i         (alu_pop),
        .head_c_o      (alu_head),
        .empty_c_o     (alu_empty),
        .near_full_c_o (alu_near_full),
        .drop_c_o      (alu_drop)
    );

    result_fifo u_lsb_fifo (
        .clk           (clockIn),
        .rst_n         (resetIn),
        .en_i          (readyIn),
        .flush_i       (flushIn),
        .push_i        (lsb_push),
        .data_i        (lsb_in),
        .pop_i         (lsb_pop),
        .head_c_o      (lsb_head),
        .empty_c_o     (lsb_empty),
        .near_full_c_o (lsb_near_full),
        .drop_c_o      (lsb_drop)
    );

    // Flush kills the broadcast but keeps round-robin history and the sticky overflow.
    always_comb begin : arb_next
        bcast_d    = bcast_q;
        last_d     = last_q;
        overflow_d = overflow_q || alu_drop || lsb_drop;
        if (readyIn) begin
            if (flushIn) begin
                bcast_d.flag = 1'b0;
            end else if (grant_vld) begin
                bcast_d.flag = 1'b1;
                bcast_d.src  = grant_src;
                bcast_d.rec  = grant_rec;
                last_d       = grant_src;
            end else begin
                bcast_d.flag = 1'b0;
            end
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin : arb_regs
        if (!resetIn) begin
            bcast_q    <= '0;
            last_q     <= SRC_LSB;
            overflow_q <= 1'b0;
        end else begin
            bcast_q    <= bcast_d;
            last_q     <= last_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.cdbFlag  = bcast_q.flag;
    assign bus.cdbSrc   = bcast_q.src;
    assign bus.cdbVal   = bcast_q.rec.val;
    assign bus.cdbDest  = bcast_q.rec.dest;
    assign bus.overflow = overflow_q;
    assign bus.aluStall = alu_near_full;
    assign bus.lsbStall = lsb_near_full;

endmodule
